// File: rtl/id_issue_pkg.sv
// Shared instruction encodings, datapath widths and issue-stage types for id_issue.
package id_issue_pkg;
    localparam int XLEN_ADDR    = 32;
    localparam int OPCODE_WIDTH = 7;
    localparam int FUNCT3_WIDTH = 3;
    localparam int FUNCT7_WIDTH = 7;
    localparam int REG_AW       = 5;
    localparam int NREG_DEF     = 32;

    localparam logic [OPCODE_WIDTH-1:0] INST_OP_TYPE_R   = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] INST_OP_TYPE_IMM = 7'b0010011;
    localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SLL       = 3'b001;
    localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SRX       = 3'b101;

    typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;

    function automatic logic [XLEN_ADDR-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN_ADDR-12){imm[11]}}, imm};
    endfunction
endpackage

// File: rtl/id_issue_if.sv
// Instruction-in, operands-out and writeback signals of the decode/issue stage.
// Both handshakes: a transfer happens on a rising edge where valid && ready; valid
// never waits on ready, and the source holds its payload until the transfer.
interface id_issue_if;
    import id_issue_pkg::*;
    logic                    inst_valid;
    logic [31:0]             inst;
    logic                    inst_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [FUNCT3_WIDTH-1:0] funct3;
    logic [FUNCT7_WIDTH-1:0] funct7;
    logic [XLEN_ADDR-1:0]    rs1;
    logic [XLEN_ADDR-1:0]    rs2;
    logic [REG_AW-1:0]       rd_addr;
    logic                    wb_en;
    logic [REG_AW-1:0]       wb_addr;
    logic [XLEN_ADDR-1:0]    wb_data;
    logic                    illegal;

    modport master (
        output inst_valid, inst, out_ready, wb_en, wb_addr, wb_data,
        input  inst_ready, out_valid, opcode, funct3, funct7, rs1, rs2, rd_addr, illegal
    );
    modport slave (
        input  inst_valid, inst, out_ready, wb_en, wb_addr, wb_data,
        output inst_ready, out_valid, opcode, funct3, funct7, rs1, rs2, rd_addr, illegal
    );
endinterface

// File: rtl/id_issue_regfile.sv
// Register file: two async read ports with write-first bypass, one sync write port, x0 = 0.
module id_issue_regfile
    import id_issue_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_AW-1:0]    ra1,
    input  logic [REG_AW-1:0]    ra2,
    output logic [XLEN_ADDR-1:0] rd1,
    output logic [XLEN_ADDR-1:0] rd2,
    input  logic                 we,
    input  logic [REG_AW-1:0]    wa,
    input  logic [XLEN_ADDR-1:0] wd
);
    logic [XLEN_ADDR-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = mem[ra1];
        rd2 = mem[ra2];
        if (we && wa == ra1) rd1 = wd;
        if (we && wa == ra2) rd2 = wd;
        if (ra1 == '0) rd1 = '0;
        if (ra2 == '0) rd2 = '0;
    end
endmodule

// File: rtl/id_issue.sv
// Decode/issue stage for the R-type ALU with busy-bit scoreboard and one-entry output register.
// Optional feature macro: RUA_ALU_IMM_EN (OP-IMM issued as R-type with immediate in rs2).
module id_issue
    import id_issue_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic            clk,
    input  logic            rst,
    id_issue_if.slave       bus,
    output logic [NREG-1:0] busy,
    output out_state_e      state
);
    logic [OPCODE_WIDTH-1:0] opc;
    logic [REG_AW-1:0]       rd_f, rs1_f, rs2_f;
    logic [FUNCT3_WIDTH-1:0] f3;
    logic [FUNCT7_WIDTH-1:0] f7;
    logic                    is_r, is_imm, legal;
    logic                    blk_rs1, blk_rs2, blk_rd, hazard;
    logic                    accept, issue;
    logic [XLEN_ADDR-1:0]    v1, v2, rs2_iss;
    logic [FUNCT7_WIDTH-1:0] f7_iss;
    logic [NREG-1:0]         busy_n;
    out_state_e              state_n;

    assign opc   = bus.inst[6:0];
    assign rd_f  = bus.inst[11:7];
    assign f3    = bus.inst[14:12];
    assign rs1_f = bus.inst[19:15];
    assign rs2_f = bus.inst[24:20];
    assign f7    = bus.inst[31:25];

    assign is_r = (opc == INST_OP_TYPE_R);
`ifdef RUA_ALU_IMM_EN
    assign is_imm = (opc == INST_OP_TYPE_IMM);
`else
    assign is_imm = 1'b0;
`endif
    assign legal = is_r || is_imm;

    // A writeback to the same index this cycle frees the register in time to issue.
    assign blk_rs1 = busy[rs1_f] && !(bus.wb_en && bus.wb_addr == rs1_f);
    assign blk_rs2 = is_r && busy[rs2_f] && !(bus.wb_en && bus.wb_addr == rs2_f);
    assign blk_rd  = (rd_f != '0) && busy[rd_f] && !(bus.wb_en && bus.wb_addr == rd_f);
    assign hazard  = legal && (blk_rs1 || blk_rs2 || blk_rd);

    assign bus.out_valid  = (state == OUT_FULL);
    assign bus.inst_ready = (!bus.out_valid || bus.out_ready) && !hazard;
    assign accept         = bus.inst_valid && bus.inst_ready;
    assign issue          = accept && legal;

    id_issue_regfile #(.NREG(NREG)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_f),
        .ra2 (rs2_f),
        .rd1 (v1),
        .rd2 (v2),
        .we  (bus.wb_en),
        .wa  (bus.wb_addr),
        .wd  (bus.wb_data)
    );

    always_comb begin
        rs2_iss = v2;
        f7_iss  = f7;
`ifdef RUA_ALU_IMM_EN
        if (is_imm) begin
            rs2_iss = sext12(bus.inst[31:20]);
            f7_iss  = (f3 == FUNCT3_SLL || f3 == FUNCT3_SRX) ? f7 : '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= OUT_EMPTY;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            OUT_EMPTY: if (issue) state_n = OUT_FULL;
            OUT_FULL:  if (bus.out_ready && !issue) state_n = OUT_EMPTY;
        endcase
    end

    // Issue-set is applied after the writeback clear so it wins on the same bit.
    always_comb begin
        busy_n = busy;
        if (bus.wb_en) busy_n[bus.wb_addr] = 1'b0;
        if (issue && rd_f != '0) busy_n[rd_f] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            bus.illegal <= 1'b0;
            bus.opcode  <= '0;
            bus.funct3  <= '0;
            bus.funct7  <= '0;
            bus.rs1     <= '0;
            bus.rs2     <= '0;
            bus.rd_addr <= '0;
        end else begin
            busy        <= busy_n;
            bus.illegal <= accept && !legal;
            if (issue) begin
                bus.opcode  <= INST_OP_TYPE_R;
                bus.funct3  <= f3;
                bus.funct7  <= f7_iss;
                bus.rs1     <= v1;
                bus.rs2     <= rs2_iss;
                bus.rd_addr <= rd_f;
            end
        end
    end
endmodule
